// File: rtl/xgmii32_frame_switch_if.sv
// XGMII-32 crossbar bus: source lanes in, routed sink lanes and status out.
// slave = switch side, master = the logic feeding and observing it.
interface xgmii32_frame_switch_if #(
    parameter int NUM_IN  = 3,
    parameter int NUM_OUT = 3,
    parameter int CNT_W   = 32
);
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*32-1:0]     rx_data;
    logic [NUM_IN*4-1:0]      rx_ctrl;
    logic [NUM_IN-1:0]        rx_valid;
    logic [NUM_OUT*SEL_W-1:0] sel;
    logic [NUM_OUT-1:0]       out_en;
    logic [NUM_OUT*32-1:0]    tx_data;
    logic [NUM_OUT*4-1:0]     tx_ctrl;
    logic [NUM_OUT*SEL_W-1:0] cur_sel;
    logic [NUM_OUT-1:0]       busy;
    logic [NUM_OUT*CNT_W-1:0] frame_cnt;
    logic [NUM_OUT*CNT_W-1:0] abort_cnt;

    modport slave (
        input  rx_data, rx_ctrl, rx_valid, sel, out_en,
        output tx_data, tx_ctrl, cur_sel, busy, frame_cnt, abort_cnt
    );

    modport master (
        output rx_data, rx_ctrl, rx_valid, sel, out_en,
        input  tx_data, tx_ctrl, cur_sel, busy, frame_cnt, abort_cnt
    );
endinterface

// File: rtl/xgmii32_frame_switch.sv
// NUM_IN x NUM_OUT XGMII-32 crossbar; each output switches source only
// between frames and flags mid-frame source loss with error words.
module xgmii32_frame_switch #(
    parameter int NUM_IN  = 3,
    parameter int NUM_OUT = 3,
    parameter int CNT_W   = 32
) (
    input logic                   clk,
    input logic                   rst,
    xgmii32_frame_switch_if.slave sw
);
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    localparam logic [31:0] IDLE_D = 32'h07070707;
    localparam logic [31:0] ERR_D  = 32'hFEFEFEFE;
    localparam logic [3:0]  CW_C   = 4'hF;

    typedef enum logic [1:0] {
        S_OFF,
        S_ARMED,
        S_FWD
    } state_t;

    logic [NUM_OUT-1:0][31:0]      tx_data_a;
    logic [NUM_OUT-1:0][3:0]       tx_ctrl_a;
    logic [NUM_OUT-1:0][SEL_W-1:0] cur_sel_a;
    logic [NUM_OUT-1:0][CNT_W-1:0] frame_a;
    logic [NUM_OUT-1:0][CNT_W-1:0] abort_a;
    logic [NUM_OUT-1:0]            busy_a;

    assign sw.tx_data   = tx_data_a;
    assign sw.tx_ctrl   = tx_ctrl_a;
    assign sw.cur_sel   = cur_sel_a;
    assign sw.frame_cnt = frame_a;
    assign sw.abort_cnt = abort_a;
    assign sw.busy      = busy_a;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        state_t           state_q, state_d;
        logic [SEL_W-1:0] sel_g, cur_sel_q, cur_sel_d;
        logic             sel_ok, en;
        logic [31:0]      src_d;
        logic [3:0]       src_c;
        logic             src_v, is_start, is_term, any_fd;
        logic [31:0]      tx_data_q, tx_data_d;
        logic [3:0]       tx_ctrl_q, tx_ctrl_d;
        logic [CNT_W-1:0] frame_q, abort_q;
        logic             frame_inc, abort_inc;

        assign sel_g  = sw.sel[g*SEL_W +: SEL_W];
        assign sel_ok = 32'(sel_g) < NUM_IN;
        assign en     = sw.out_en[g];

        always_comb begin
            src_d = IDLE_D;
            src_c = CW_C;
            src_v = 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (cur_sel_q == SEL_W'(i)) begin
                    src_d = sw.rx_data[32*i +: 32];
                    src_c = sw.rx_ctrl[4*i +: 4];
                    src_v = sw.rx_valid[i];
                end
            end
        end

        always_comb begin
            any_fd = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (src_c[k] && src_d[8*k +: 8] == 8'hFD) any_fd = 1'b1;
            end
        end

        assign is_start = src_v && src_c[0] && src_d[7:0] == 8'hFB;
        assign is_term  = src_v && any_fd;

        always_ff @(posedge clk) begin
            if (rst) state_q <= S_OFF;
            else     state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            unique case (state_q)
                S_OFF: begin
                    if (en && sel_ok) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (!en)           state_d = S_OFF;
                    else if (is_start) state_d = S_FWD;
                end
                S_FWD: begin
                    if (!src_v || is_term) state_d = S_ARMED;
                end
                default: state_d = S_OFF;
            endcase
        end

        // The START edge keeps cur_sel, so a same-cycle sel change cannot splice.
        always_comb begin
            tx_data_d = IDLE_D;
            tx_ctrl_d = CW_C;
            cur_sel_d = cur_sel_q;
            frame_inc = 1'b0;
            abort_inc = 1'b0;
            unique case (state_q)
                S_OFF: begin
                    if (en && sel_ok) cur_sel_d = sel_g;
                end
                S_ARMED: begin
                    if (en && is_start) begin
                        tx_data_d = src_d;
                        tx_ctrl_d = src_c;
                    end else if (sel_ok) begin
                        cur_sel_d = sel_g;
                    end
                end
                S_FWD: begin
                    if (!src_v) begin
                        tx_data_d = ERR_D;
                        abort_inc = 1'b1;
                    end else if (is_term) begin
                        tx_data_d = src_d;
                        tx_ctrl_d = src_c;
                        frame_inc = 1'b1;
                    end else if (is_start) begin
                        tx_data_d = ERR_D;
                        abort_inc = 1'b1;
                    end else begin
                        tx_data_d = src_d;
                        tx_ctrl_d = src_c;
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                tx_data_q <= IDLE_D;
                tx_ctrl_q <= CW_C;
                cur_sel_q <= '0;
                frame_q   <= '0;
                abort_q   <= '0;
            end else begin
                tx_data_q <= tx_data_d;
                tx_ctrl_q <= tx_ctrl_d;
                cur_sel_q <= cur_sel_d;
                if (frame_inc && frame_q != '1) frame_q <= frame_q + CNT_W'(1);
                if (abort_inc && abort_q != '1) abort_q <= abort_q + CNT_W'(1);
            end
        end

        assign tx_data_a[g] = tx_data_q;
        assign tx_ctrl_a[g] = tx_ctrl_q;
        assign cur_sel_a[g] = cur_sel_q;
        assign frame_a[g]   = frame_q;
        assign abort_a[g]   = abort_q;
        assign busy_a[g]    = state_q == S_FWD;
    end
endmodule
